// File: rtl/mem_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the memory/bus fabric (slave).
// Address is word aligned; sel carries the byte lanes of the access.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output req, we, addr, sel, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data bus, steers byte lanes,
// extends load data and flags misaligned or failed accesses. Non-memory ops pass straight through.
module mem_stage #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [5:0]  stalled,
  output logic        stallreq_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        exc_misalign_o,
  output logic        exc_bus_o,
  output logic [31:0] exc_addr_o,
  mem_stage_if.master dbus
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic              req_reg, we_reg;
  logic [31:0]       addr_reg, wdata_reg, rdata_reg;
  logic [3:0]        sel_reg;
  logic [TO_W-1:0]   cnt_reg;
  logic              err_reg;
  logic              load_reg, uns_reg;
  logic [1:0]        size_reg, off_reg;

  logic              is_mem, is_load, is_uns, aligned, start, timed_out, bus_fail;
  logic [1:0]        size;
  logic [3:0]        sel_calc;
  logic [31:0]       st_data, ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Only bit 4 of the stall vector concerns this stage.
  logic unused_stall;
  assign unused_stall = ^{stalled[5], stalled[3:0]};

  always_comb begin
    is_mem  = 1'b1;
    is_load = 1'b1;
    is_uns  = 1'b0;
    size    = SZ_W;
    case (mem_aluop_i)
      EXE_LB_OP:  size = SZ_B;
      EXE_LBU_OP: begin size = SZ_B; is_uns = 1'b1; end
      EXE_LH_OP:  size = SZ_H;
      EXE_LHU_OP: begin size = SZ_H; is_uns = 1'b1; end
      EXE_LW_OP:  size = SZ_W;
      EXE_SB_OP:  begin size = SZ_B; is_load = 1'b0; end
      EXE_SH_OP:  begin size = SZ_H; is_load = 1'b0; end
      EXE_SW_OP:  begin size = SZ_W; is_load = 1'b0; end
      default:    begin is_mem = 1'b0; is_load = 1'b0; end
    endcase
  end

  always_comb begin
    aligned  = 1'b1;
    sel_calc = 4'hF;
    case (size)
      SZ_B: sel_calc = 4'b0001 << mem_addr_i[1:0];
      SZ_H: begin
        aligned  = ~mem_addr_i[0];
        sel_calc = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: aligned = (mem_addr_i[1:0] == 2'b00);
    endcase
  end

  // Store data is replicated so every enabled lane already carries the right bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign st_data[gi*8 +: 8] = (size == SZ_B) ? mem_reg2_i[7:0] :
                                  (size == SZ_H) ? mem_reg2_i[(gi%2)*8 +: 8] :
                                                   mem_reg2_i[gi*8 +: 8];
    end
  endgenerate

  assign timed_out = (TIMEOUT != 0) && (cnt_reg == TO_LAST);
  assign bus_fail  = dbus.err || timed_out;

  always_comb begin
    ld_byte = rdata_reg[{off_reg, 3'b000} +: 8];
    ld_half = off_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
    case (size_reg)
      SZ_B:    ld_ext = uns_reg ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_ext = uns_reg ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = rdata_reg;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    start          = 1'b0;
    stallreq_o     = 1'b0;
    wd_o           = mem_wd_i;
    wreg_o         = mem_wreg_i;
    wdata_o        = mem_wdata_i;
    exc_misalign_o = 1'b0;
    exc_bus_o      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_mem) begin
          if (!aligned) begin
            exc_misalign_o = 1'b1;
            wreg_o         = 1'b0;
          end else begin
            stallreq_o = 1'b1;
            start      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (bus_fail || dbus.ack)
          state_next = DONE;
      end
      default: begin
        if (load_reg)
          wdata_o = ld_ext;
        if (err_reg) begin
          wreg_o    = 1'b0;
          exc_bus_o = 1'b1;
        end
        if (!stalled[4])
          state_next = IDLE;
      end
    endcase
  end

  assign exc_addr_o = mem_addr_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      sel_reg   <= 4'h0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      load_reg  <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= SZ_W;
      off_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (start) begin
        req_reg   <= 1'b1;
        we_reg    <= ~is_load;
        sel_reg   <= sel_calc;
        addr_reg  <= {mem_addr_i[31:2], 2'b00};
        wdata_reg <= st_data;
        cnt_reg   <= '0;
        err_reg   <= 1'b0;
        load_reg  <= is_load;
        uns_reg   <= is_uns;
        size_reg  <= size;
        off_reg   <= mem_addr_i[1:0];
      end else if (state_reg == BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
        // An error reported together with ack takes priority.
        if (bus_fail) begin
          err_reg <= 1'b1;
          req_reg <= 1'b0;
        end else if (dbus.ack) begin
          rdata_reg <= dbus.rdata;
          req_reg   <= 1'b0;
        end
      end
    end
  end

  assign dbus.req   = req_reg;
  assign dbus.we    = we_reg;
  assign dbus.sel   = sel_reg;
  assign dbus.addr  = addr_reg;
  assign dbus.wdata = wdata_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table driven through a bus responder with a
// result scoreboard, plus hand sequences for reset, async reset mid-access and stall hold.
module tb_mem_stage;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_reg2_i;
  logic [5:0]  stalled;
  logic        stallreq_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        exc_misalign_o;
  logic        exc_bus_o;
  logic [31:0] exc_addr_o;

  mem_stage_if dbus();

  always #5 clk = ~clk;

  mem_stage #(.TO_W(8), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .mem_wd_i(mem_wd_i),
    .mem_wreg_i(mem_wreg_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_aluop_i(mem_aluop_i),
    .mem_addr_i(mem_addr_i),
    .mem_reg2_i(mem_reg2_i),
    .stalled(stalled),
    .stallreq_o(stallreq_o),
    .wd_o(wd_o),
    .wreg_o(wreg_o),
    .wdata_o(wdata_o),
    .exc_misalign_o(exc_misalign_o),
    .exc_bus_o(exc_bus_o),
    .exc_addr_o(exc_addr_o),
    .dbus(dbus)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata_in;
    logic [31:0] rdata;
    int          ack_at;   // BUSY cycle (1-based) on which ack is given, 0 = never
    int          err_at;   // BUSY cycle on which err is given, 0 = never
    int          e_stall;
    int          e_req;
    logic [31:0] e_baddr;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_bwdata;
    bit          chk_bw;
    logic        e_wreg;
    logic [31:0] e_wdata;
    bit          chk_wd;
    logic        e_mis;
    logic        e_bus;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    mem_aluop_i = op;
    mem_addr_i  = addr;
    mem_reg2_i  = rs2;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
    mem_wdata_i = wdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   stall_n;
    int   req_n;
    bit   got;
    @(negedge clk);
    drive(v.op, v.addr, v.rs2, v.wd, v.wreg, v.wdata_in);
    stalled = 6'b0;
    exp_q.push_back(v);
    stall_n = 0;
    req_n   = 0;
    got     = 1'b0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      #1;
      if (dbus.req) begin
        req_n++;
        chk($sformatf("v%0d bus_addr", idx), dbus.addr, v.e_baddr);
        chk($sformatf("v%0d bus_sel", idx), 32'(dbus.sel), 32'(v.e_sel));
        chk($sformatf("v%0d bus_we", idx), 32'(dbus.we), 32'(v.e_we));
        if (v.chk_bw)
          chk($sformatf("v%0d bus_wdata", idx), dbus.wdata, v.e_bwdata);
      end
      if (!stallreq_o) begin
        got = 1'b1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d stall_cycles", idx), 32'(stall_n), 32'(e.e_stall));
        chk($sformatf("v%0d req_cycles", idx), 32'(req_n), 32'(e.e_req));
        chk($sformatf("v%0d wd_o", idx), 32'(wd_o), 32'(e.wd));
        chk($sformatf("v%0d wreg_o", idx), 32'(wreg_o), 32'(e.e_wreg));
        if (e.chk_wd)
          chk($sformatf("v%0d wdata_o", idx), wdata_o, e.e_wdata);
        chk($sformatf("v%0d exc_misalign", idx), 32'(exc_misalign_o), 32'(e.e_mis));
        chk($sformatf("v%0d exc_bus", idx), 32'(exc_bus_o), 32'(e.e_bus));
        if (e.e_mis || e.e_bus)
          chk($sformatf("v%0d exc_addr", idx), exc_addr_o, e.addr);
        $display("vec %0d op=%h addr=%h: stall=%0d req=%0d wreg=%b wdata=%h mis=%b bus=%b",
                 idx, v.op, v.addr, stall_n, req_n, wreg_o, wdata_o, exc_misalign_o, exc_bus_o);
      end else begin
        stall_n++;
        dbus.ack   = dbus.req && (req_n == v.ack_at);
        dbus.err   = dbus.req && (req_n == v.err_at);
        dbus.rdata = dbus.ack ? v.rdata : 32'h0BAD_0BAD;
        @(negedge clk);
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d result: got no result within 40 cycles, expected stallreq_o to drop", idx);
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end
    // Retire the op before the next edge so DONE returns to IDLE without a new access.
    mem_aluop_i = OP_NOP;
    dbus.ack    = 1'b0;
    dbus.err    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op      addr          rs2           wd    wr    wdata_in      rdata         ack err st req baddr         sel      we    bwdata        cbw   ewr   ewdata        cwd   mis   bus
    vecs.push_back('{OP_NOP, 32'h0000_0000, 32'h0,        5'd3, 1'b1, 32'h1111_2222, 32'h0,        0, 0, 0, 0, 32'h0,        4'h0,    1'b0, 32'h0,        1'b0, 1'b1, 32'h1111_2222, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h0000_0100, 32'h0,        5'd4, 1'b1, 32'h0,        32'hDEAD_BEEF, 2, 0, 3, 2, 32'h0000_0100, 4'hF,    1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LB,  32'h0000_0103, 32'h0,        5'd5, 1'b1, 32'h0,        32'h80FF_FF7F, 1, 0, 2, 1, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LBU, 32'h0000_0103, 32'h0,        5'd6, 1'b1, 32'h0,        32'h80FF_FF7F, 1, 0, 2, 1, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LH,  32'h0000_0102, 32'h0,        5'd7, 1'b1, 32'h0,        32'h80FF_FF7F, 1, 0, 2, 1, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LHU, 32'h0000_0100, 32'h0,        5'd8, 1'b1, 32'h0,        32'h80FF_FF7F, 3, 0, 4, 3, 32'h0000_0100, 4'b0011, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_FF7F, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LB,  32'h0000_0100, 32'h0,        5'd9, 1'b1, 32'h0,        32'h80FF_FF7F, 1, 0, 2, 1, 32'h0000_0100, 4'b0001, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_007F, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_SH,  32'h0000_0202, 32'h1234_ABCD, 5'd0, 1'b0, 32'h0,        32'h0,        1, 0, 2, 1, 32'h0000_0200, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SB,  32'h0000_0201, 32'h0000_00A5, 5'd0, 1'b0, 32'h0,        32'h0,        2, 0, 3, 2, 32'h0000_0200, 4'b0010, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SW,  32'h0000_0204, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0,        32'h0,        1, 0, 2, 1, 32'h0000_0204, 4'hF,    1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h0000_0101, 32'h0,        5'd10, 1'b1, 32'h0,       32'h0,        1, 0, 0, 0, 32'h0,        4'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{OP_SH,  32'h0000_0203, 32'h5555_6666, 5'd0, 1'b0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        4'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{OP_LHU, 32'h0000_0101, 32'h0,        5'd11, 1'b1, 32'h0,       32'h0,        1, 0, 0, 0, 32'h0,        4'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0});
    vecs.push_back('{OP_LW,  32'h0000_0300, 32'h0,        5'd12, 1'b1, 32'h0,       32'h0,        0, 0, 5, 4, 32'h0000_0300, 4'hF,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_LW,  32'h0000_0304, 32'h0,        5'd13, 1'b1, 32'h0,       32'h0,        0, 2, 3, 2, 32'h0000_0304, 4'hF,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_LW,  32'h0000_0308, 32'h0,        5'd14, 1'b1, 32'h0,       32'h1357_9BDF, 1, 1, 2, 1, 32'h0000_0308, 4'hF,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{OP_LW,  32'h0000_030C, 32'h0,        5'd15, 1'b1, 32'h0,       32'h0123_4567, 1, 0, 2, 1, 32'h0000_030C, 4'hF,    1'b0, 32'h0,        1'b0, 1'b1, 32'h0123_4567, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_SB,  32'h0000_0203, 32'h0000_00FF, 5'd0, 1'b0, 32'h0,        32'h0,        1, 0, 2, 1, 32'h0000_0200, 4'b1000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0});

    // Reset state with a non-memory op applied.
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    stalled    = 6'b0;
    dbus.ack   = 1'b0;
    dbus.err   = 1'b0;
    dbus.rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset req", 32'(dbus.req), 32'd0);
    chk("reset we", 32'(dbus.we), 32'd0);
    chk("reset sel", 32'(dbus.sel), 32'd0);
    chk("reset addr", dbus.addr, 32'd0);
    chk("reset bus_wdata", dbus.wdata, 32'd0);
    chk("reset stallreq", 32'(stallreq_o), 32'd0);
    chk("reset exc_bus", 32'(exc_bus_o), 32'd0);
    $display("reset: req=%b sel=%h addr=%h stallreq=%b", dbus.req, dbus.sel, dbus.addr, stallreq_o);
    @(negedge clk);
    rst = 1'b1;

    // ack/err while idle must not start anything or leave an error behind.
    @(negedge clk);
    dbus.ack = 1'b1;
    dbus.err = 1'b1;
    @(negedge clk);
    dbus.ack = 1'b0;
    dbus.err = 1'b0;
    #1;
    chk("idle_ack stallreq", 32'(stallreq_o), 32'd0);
    chk("idle_ack req", 32'(dbus.req), 32'd0);
    chk("idle_ack exc_bus", 32'(exc_bus_o), 32'd0);
    $display("idle ack/err pulse: stallreq=%b req=%b exc_bus=%b", stallreq_o, dbus.req, exc_bus_o);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of a BUSY access.
    @(negedge clk);
    drive(OP_LW, 32'h0000_0400, 32'h0, 5'd1, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    chk("arst busy req", 32'(dbus.req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst req dropped", 32'(dbus.req), 32'd0);
    chk("arst addr cleared", dbus.addr, 32'd0);
    $display("async reset mid-access: req=%b addr=%h", dbus.req, dbus.addr);
    mem_aluop_i = OP_NOP;
    @(negedge clk);
    rst = 1'b1;
    run_vec(100, '{OP_LW, 32'h0000_0404, 32'h0, 5'd2, 1'b1, 32'h0, 32'h2468_ACE0, 1, 0, 2, 1,
                   32'h0000_0404, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2468_ACE0, 1'b1, 1'b0, 1'b0});

    // DONE must hold while the MEM stage is stalled, ignoring stray acks.
    @(negedge clk);
    drive(OP_LW, 32'h0000_0500, 32'h0, 5'd9, 1'b1, 32'h0);
    stalled = 6'b01_0000;
    #1;
    chk("hold idle stallreq", 32'(stallreq_o), 32'd1);
    @(negedge clk);
    #1;
    dbus.ack   = 1'b1;
    dbus.rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    dbus.ack   = 1'b0;
    dbus.rdata = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d stallreq", k), 32'(stallreq_o), 32'd0);
      chk($sformatf("hold%0d req", k), 32'(dbus.req), 32'd0);
      chk($sformatf("hold%0d wdata_o", k), wdata_o, 32'h5A5A_5A5A);
      chk($sformatf("hold%0d wreg_o", k), 32'(wreg_o), 32'd1);
      $display("stall hold %0d: stallreq=%b wdata=%h", k, stallreq_o, wdata_o);
      dbus.ack   = 1'b1;
      dbus.rdata = 32'h1234_5678;
      @(negedge clk);
      dbus.ack   = 1'b0;
    end
    stalled     = 6'b0;
    mem_aluop_i = OP_NOP;
    mem_wdata_i = 32'h7777_7777;
    #1;
    chk("release still done", wdata_o, 32'h5A5A_5A5A);
    @(negedge clk);
    #1;
    chk("release back idle", wdata_o, 32'h7777_7777);
    chk("release stallreq", 32'(stallreq_o), 32'd0);
    $display("stall released: wdata=%h stallreq=%b", wdata_o, stallreq_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
